// File: rtl/stdp_mux_pkg.sv
// Shared types and constants for the STDP channel scan mux.
// Optional feature macro: STDP_SCAN_MASK_EN (see stdp_chan_scan_mux).
package stdp_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/stdp_next_chan.sv
// Combinational priority finder: lowest set mask bit at or above i_from.
// o_none is set when no enabled channel remains (i_from may equal NUM_CH).
module stdp_next_chan #(
  parameter  int unsigned NUM_CH = 16,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [SEL_W:0]    i_from,
  output logic [SEL_W-1:0]  o_next,
  output logic              o_none
);

  // Descending walk so the lowest qualifying bit is the last one written.
  always_comb begin
    o_next = '0;
    o_none = 1'b1;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (i_mask[i] && ((SEL_W+1)'(i) >= i_from)) begin
        o_next = SEL_W'(i);
        o_none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stdp_chan_scan_mux.sv
// Registered N:1 channel selector with direct (random access) and scan (round-robin) modes.
// Optional macro STDP_SCAN_MASK_EN adds ch_mask to skip disabled channels during a scan.
module stdp_chan_scan_mux
  import stdp_mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned NUM_CH = 16,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data [0:NUM_CH-1],
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_valid,
  output logic              sel_ready,
  input  logic              start,
  output logic [WIDTH-1:0]  out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef STDP_SCAN_MASK_EN
  input  logic [NUM_CH-1:0] ch_mask,
`endif
  output logic              busy,
  output logic              done
);

  scan_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0]  r_idx, w_idx_nxt;
  logic [WIDTH-1:0]  r_out_data, w_out_data_nxt;
  logic [SEL_W-1:0]  r_out_ch, w_out_ch_nxt;
  logic              r_out_last, w_out_last_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic              w_slot_free;
  logic              w_sel_ready;
  logic [WIDTH-1:0]  w_sel_data;
  logic [NUM_CH-1:0] w_mask;
  logic [SEL_W:0]    w_from;
  logic [SEL_W-1:0]  w_next;
  logic              w_none;

`ifdef STDP_SCAN_MASK_EN
  logic [NUM_CH-1:0] r_mask;

  // Mask tracks the port while idle and freezes for the duration of a scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if (r_state == IDLE) begin
      r_mask <= ch_mask;
    end
  end

  assign w_mask = (r_state == IDLE) ? ch_mask : r_mask;
`else
  // With every channel enabled the finder reduces to idx+1.
  assign w_mask = '1;
`endif

  // Idle searches for the first channel; in scan, for the one after the current idx.
  assign w_from = (r_state == IDLE) ? '0
                                    : ((SEL_W+1)'(r_idx) + (SEL_W+1)'(1));

  stdp_next_chan #(
    .NUM_CH (NUM_CH)
  ) u_next_chan (
    .i_mask (w_mask),
    .i_from (w_from),
    .o_next (w_next),
    .o_none (w_none)
  );

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_sel_ready = w_slot_free && (r_state == IDLE) && (mode == MODE_DIRECT);

  // Out-of-range direct index still yields a valid beat carrying zero.
  always_comb begin
    w_sel_data = '0;
    if (32'(sel) < NUM_CH) begin
      w_sel_data = in_data[sel];
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_out_data_nxt  = r_out_data;
    w_out_ch_nxt    = r_out_ch;
    w_out_last_nxt  = r_out_last;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_done_nxt      = r_out_valid && out_ready && r_out_last;

    case (r_state)
      IDLE: begin
        if (start && (mode == MODE_SCAN)) begin
          if (w_none) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = SCAN;
            w_idx_nxt   = w_next;
          end
        end else if (sel_valid && w_sel_ready) begin
          w_out_data_nxt  = w_sel_data;
          w_out_ch_nxt    = sel;
          w_out_last_nxt  = 1'b0;
          w_out_valid_nxt = 1'b1;
        end
      end
      SCAN: begin
        if (w_slot_free) begin
          w_out_data_nxt  = in_data[r_idx];
          w_out_ch_nxt    = r_idx;
          w_out_last_nxt  = w_none;
          w_out_valid_nxt = 1'b1;
          if (w_none) begin
            w_state_nxt = IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt   = w_next;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == SCAN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_ch    <= w_out_ch_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign sel_ready = w_sel_ready;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
